// File: rtl/icache_nway.sv
// N-way set-associative instruction cache with burst line refill, kseg1 uncached
// bypass and a one-set-per-cycle whole-cache invalidate.
module icache_nway #(
   parameter int NUM_WAYS     = 4,
   parameter int INDEX_WIDTH  = 4,
   parameter int OFFSET_WIDTH = 6
) (
   input  logic        cache_clk,
   input  logic        cache_rst,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic        operation_ok,
   output logic [31:0] cpu_rdata,
   input  logic        inv_req,
   output logic        inv_done,
   output logic        ram_req,
   output logic        ram_wr,
   output logic        ram_uncached,
   output logic [31:0] ram_addr,
   output logic [7:0]  ram_len,
   output logic [31:0] ram_wdata,
   input  logic        ram_addr_ok,
   input  logic        ram_beat_ok,
   input  logic        ram_data_ok,
   input  logic [31:0] ram_rdata
);
   localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
   localparam int WORD_WIDTH = OFFSET_WIDTH - 2;
   localparam int WORDS      = 2 ** WORD_WIDTH;
   localparam int NUM_SETS   = 2 ** INDEX_WIDTH;
   localparam int WAY_WIDTH  = $clog2(NUM_WAYS);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOOKUP   = 3'd1,
      MISS_REQ = 3'd2,
      REFILL   = 3'd3,
      UC_REQ   = 3'd4,
      UC_WAIT  = 3'd5,
      INV      = 3'd6
   } state_t;

   state_t                  state_r, next_state_s;
   logic [31:0]             req_addr_r;
   logic [WORD_WIDTH-1:0]   cnt_r;
   logic [INDEX_WIDTH-1:0]  inv_set_r;
   logic [WAY_WIDTH-1:0]    victim_r;
   logic [NUM_SETS-1:0]     valid_r [NUM_WAYS];
   logic [WAY_WIDTH-1:0]    age_r [NUM_SETS][NUM_WAYS];
   logic [TAG_WIDTH-1:0]    tag_mem_r [NUM_WAYS][NUM_SETS];
   logic [31:0]             data_mem_r [NUM_WAYS][NUM_SETS][WORDS];

   logic [TAG_WIDTH-1:0]    req_tag_s;
   logic [INDEX_WIDTH-1:0]  idx_s;
   logic [WORD_WIDTH-1:0]   word_s;
   logic                    uncached_s, hit_s, lookup_hit_s, refill_done_s, age_upd_s, last_set_s;
   logic [NUM_WAYS-1:0]     hit_vec_s;
   logic [WAY_WIDTH-1:0]    hit_way_s, victim_s, upd_way_s;
   logic                    ok_nxt_s, inv_done_nxt_s, req_nxt_s, uc_nxt_s;
   logic [31:0]             rdata_nxt_s, addr_nxt_s;
   logic [7:0]              len_nxt_s;

   assign req_tag_s     = req_addr_r[31 -: TAG_WIDTH];
   assign idx_s         = req_addr_r[OFFSET_WIDTH +: INDEX_WIDTH];
   assign word_s        = req_addr_r[2 +: WORD_WIDTH];
   assign uncached_s    = (req_addr_r[31:29] == 3'b101);
   assign last_set_s    = (inv_set_r == INDEX_WIDTH'(NUM_SETS - 1));
   assign refill_done_s = (state_r == REFILL) && ram_data_ok && (cnt_r == WORD_WIDTH'(WORDS - 1));
   assign lookup_hit_s  = (state_r == LOOKUP) && !uncached_s && hit_s;
   assign age_upd_s     = lookup_hit_s || refill_done_s;
   assign upd_way_s     = lookup_hit_s ? hit_way_s : victim_r;
   assign ram_wr        = 1'b0;
   assign ram_wdata     = 32'h0000_0000;

   for (genvar g = 0; g < NUM_WAYS; g++) begin : g_hit
      assign hit_vec_s[g] = valid_r[g][idx_s] && (tag_mem_r[g][idx_s] == req_tag_s);
   end

   // Hit way and victim: lowest invalid way wins, otherwise the oldest way
   always_comb begin
      hit_s     = |hit_vec_s;
      hit_way_s = {WAY_WIDTH{1'b0}};
      victim_s  = {WAY_WIDTH{1'b0}};
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         hit_way_s = hit_vec_s[w] ? WAY_WIDTH'(w) : hit_way_s;
      end
      for (int w = 0; w < NUM_WAYS; w++) begin
         victim_s = (age_r[idx_s][w] == WAY_WIDTH'(NUM_WAYS - 1)) ? WAY_WIDTH'(w) : victim_s;
      end
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         victim_s = !valid_r[w][idx_s] ? WAY_WIDTH'(w) : victim_s;
      end
   end

   // State register
   always_ff @(posedge cache_clk or posedge cache_rst) begin
      if (cache_rst) state_r <= IDLE;
      else           state_r <= next_state_s;
   end

   // Next-state logic; a pending done pulse blocks acceptance of the held request
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (operation_ok || inv_done) next_state_s = IDLE;
            else if (inv_req)             next_state_s = INV;
            else if (cpu_req)             next_state_s = LOOKUP;
            else                          next_state_s = IDLE;
         end
         LOOKUP: begin
            if (uncached_s)  next_state_s = UC_REQ;
            else if (hit_s)  next_state_s = IDLE;
            else             next_state_s = MISS_REQ;
         end
         MISS_REQ: next_state_s = ram_addr_ok ? REFILL : MISS_REQ;
         REFILL:   next_state_s = refill_done_s ? IDLE : REFILL;
         UC_REQ:   next_state_s = ram_addr_ok ? UC_WAIT : UC_REQ;
         UC_WAIT:  next_state_s = ram_data_ok ? IDLE : UC_WAIT;
         INV:      next_state_s = last_set_s ? IDLE : INV;
         default:  next_state_s = IDLE;
      endcase
   end

   // Next values of the registered outputs
   always_comb begin
      ok_nxt_s       = 1'b0;
      inv_done_nxt_s = 1'b0;
      rdata_nxt_s    = cpu_rdata;
      req_nxt_s      = (next_state_s == MISS_REQ) || (next_state_s == UC_REQ);
      uc_nxt_s       = ram_uncached;
      addr_nxt_s     = ram_addr;
      len_nxt_s      = ram_len;
      case (state_r)
         LOOKUP: begin
            ok_nxt_s    = lookup_hit_s;
            rdata_nxt_s = lookup_hit_s ? data_mem_r[hit_way_s][idx_s][word_s] : cpu_rdata;
         end
         REFILL: begin
            ok_nxt_s    = refill_done_s;
            rdata_nxt_s = (ram_beat_ok && (cnt_r == word_s)) ? ram_rdata : cpu_rdata;
         end
         UC_WAIT: begin
            ok_nxt_s    = ram_data_ok;
            rdata_nxt_s = ram_data_ok ? ram_rdata : cpu_rdata;
         end
         INV:     inv_done_nxt_s = last_set_s;
         default: ok_nxt_s = 1'b0;
      endcase
      case (next_state_s)
         MISS_REQ: begin
            uc_nxt_s   = 1'b0;
            addr_nxt_s = {req_addr_r[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
            len_nxt_s  = 8'(WORDS - 1);
         end
         UC_REQ: begin
            uc_nxt_s   = 1'b1;
            addr_nxt_s = req_addr_r;
            len_nxt_s  = 8'd0;
         end
         default: uc_nxt_s = ram_uncached;
      endcase
   end

   // Output registers
   always_ff @(posedge cache_clk or posedge cache_rst) begin
      if (cache_rst) begin
         operation_ok <= 1'b0;
         cpu_rdata    <= 32'h0000_0000;
         inv_done     <= 1'b0;
         ram_req      <= 1'b0;
         ram_uncached <= 1'b0;
         ram_addr     <= 32'h0000_0000;
         ram_len      <= 8'd0;
      end else begin
         operation_ok <= ok_nxt_s;
         cpu_rdata    <= rdata_nxt_s;
         inv_done     <= inv_done_nxt_s;
         ram_req      <= req_nxt_s;
         ram_uncached <= uc_nxt_s;
         ram_addr     <= addr_nxt_s;
         ram_len      <= len_nxt_s;
      end
   end

   // Request address, beat counter, victim, valid bits and LRU ages
   always_ff @(posedge cache_clk or posedge cache_rst) begin
      if (cache_rst) begin
         req_addr_r <= 32'h0000_0000;
         cnt_r      <= {WORD_WIDTH{1'b0}};
         inv_set_r  <= {INDEX_WIDTH{1'b0}};
         victim_r   <= {WAY_WIDTH{1'b0}};
         for (int w = 0; w < NUM_WAYS; w++) begin
            valid_r[w] <= {NUM_SETS{1'b0}};
            for (int s = 0; s < NUM_SETS; s++) age_r[s][w] <= WAY_WIDTH'(w);
         end
      end else begin
         if ((state_r == IDLE) && (next_state_s == LOOKUP)) req_addr_r <= cpu_addr;
         if (state_r == LOOKUP) victim_r <= victim_s;
         if (state_r == MISS_REQ) cnt_r <= {WORD_WIDTH{1'b0}};
         else if ((state_r == REFILL) && ram_beat_ok) cnt_r <= cnt_r + 1'b1;
         if (state_r == INV) begin
            inv_set_r <= inv_set_r + 1'b1;
            for (int w = 0; w < NUM_WAYS; w++) begin
               valid_r[w][inv_set_r] <= 1'b0;
               age_r[inv_set_r][w]   <= WAY_WIDTH'(w);
            end
         end
         if (refill_done_s) valid_r[victim_r][idx_s] <= 1'b1;
         // Touched way becomes youngest; only younger ways age, so ages stay a permutation
         if (age_upd_s) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (WAY_WIDTH'(w) == upd_way_s)
                  age_r[idx_s][w] <= {WAY_WIDTH{1'b0}};
               else if (age_r[idx_s][w] < age_r[idx_s][upd_way_s])
                  age_r[idx_s][w] <= age_r[idx_s][w] + 1'b1;
            end
         end
      end
   end

   // Tag and data arrays; no reset so they can map onto SRAM
   always_ff @(posedge cache_clk) begin
      if ((state_r == REFILL) && ram_beat_ok) data_mem_r[victim_r][idx_s][cnt_r] <= ram_rdata;
      if (refill_done_s) tag_mem_r[victim_r][idx_s] <= req_tag_s;
   end
endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway: default 4-way instance plus a 2-way/64-set/8-word instance,
// with the bench acting as CPU and SRAM-AXI bridge for whichever instance is selected.
module tb_icache_nway;
   logic        clk = 1'b0;
   logic        cache_rst = 1'b1;
   logic        sel2 = 1'b0;
   logic        cpu_req = 1'b0, inv_req = 1'b0;
   logic [31:0] cpu_addr = 32'h0;
   logic        ram_addr_ok = 1'b0, ram_beat_ok = 1'b0, ram_data_ok = 1'b0;
   logic [31:0] ram_rdata = 32'h0;
   int          checks = 0, failures = 0;
   int          lat, n;

   logic        ok1, invd1, rreq1, rwr1, ruc1, ok2, invd2, rreq2, rwr2, ruc2;
   logic [31:0] rd1, raddr1, rwd1, rd2, raddr2, rwd2;
   logic [7:0]  rlen1, rlen2;
   logic        op_ok, inv_done_m, ram_req_m, ram_wr_m, ram_uc_m;
   logic [31:0] rdata_m, ram_addr_m, ram_wdata_m;
   logic [7:0]  ram_len_m;

   always #5 clk = ~clk;

   icache_nway dut (
      .cache_clk(clk), .cache_rst(cache_rst),
      .cpu_req(cpu_req & ~sel2), .cpu_addr(cpu_addr),
      .operation_ok(ok1), .cpu_rdata(rd1),
      .inv_req(inv_req & ~sel2), .inv_done(invd1),
      .ram_req(rreq1), .ram_wr(rwr1), .ram_uncached(ruc1), .ram_addr(raddr1),
      .ram_len(rlen1), .ram_wdata(rwd1),
      .ram_addr_ok(ram_addr_ok & ~sel2), .ram_beat_ok(ram_beat_ok & ~sel2),
      .ram_data_ok(ram_data_ok & ~sel2), .ram_rdata(ram_rdata)
   );

   icache_nway #(.NUM_WAYS(2), .INDEX_WIDTH(6), .OFFSET_WIDTH(5)) dut2 (
      .cache_clk(clk), .cache_rst(cache_rst),
      .cpu_req(cpu_req & sel2), .cpu_addr(cpu_addr),
      .operation_ok(ok2), .cpu_rdata(rd2),
      .inv_req(inv_req & sel2), .inv_done(invd2),
      .ram_req(rreq2), .ram_wr(rwr2), .ram_uncached(ruc2), .ram_addr(raddr2),
      .ram_len(rlen2), .ram_wdata(rwd2),
      .ram_addr_ok(ram_addr_ok & sel2), .ram_beat_ok(ram_beat_ok & sel2),
      .ram_data_ok(ram_data_ok & sel2), .ram_rdata(ram_rdata)
   );

   assign op_ok       = sel2 ? ok2   : ok1;
   assign rdata_m     = sel2 ? rd2   : rd1;
   assign inv_done_m  = sel2 ? invd2 : invd1;
   assign ram_req_m   = sel2 ? rreq2 : rreq1;
   assign ram_wr_m    = sel2 ? rwr2  : rwr1;
   assign ram_uc_m    = sel2 ? ruc2  : ruc1;
   assign ram_addr_m  = sel2 ? raddr2 : raddr1;
   assign ram_len_m   = sel2 ? rlen2 : rlen1;
   assign ram_wdata_m = sel2 ? rwd2  : rwd1;

   task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   // CPU fetch with bridge service; exp_reqs=0 means a hit is expected
   task automatic fetch(input string tag, input logic [31:0] a, input int exp_reqs,
                        input logic exp_uc, input logic [31:0] exp_raddr, input int beats,
                        input logic [31:0] base, input logic [31:0] exp_rdata, output int latency);
      int  nreq;
      bit  done;
      nreq = 0; latency = 0; done = 1'b0;
      cpu_addr = a; cpu_req = 1'b1;
      while (!done && latency < 100) begin
         @(posedge clk); #1; latency++;
         if (op_ok) done = 1'b1;
         else if (ram_req_m) begin
            nreq++;
            check({tag, "_uncached"}, {31'd0, ram_uc_m}, {31'd0, exp_uc});
            check({tag, "_ram_addr"}, ram_addr_m, exp_raddr);
            check({tag, "_ram_len"}, {24'd0, ram_len_m}, 32'(beats - 1));
            ram_addr_ok = 1'b1;
            @(posedge clk); #1; latency++;
            ram_addr_ok = 1'b0;
            for (int i = 0; i < beats; i++) begin
               ram_rdata = base + 32'(i); ram_beat_ok = 1'b1; ram_data_ok = (i == beats - 1);
               @(posedge clk); #1; latency++;
            end
            ram_beat_ok = 1'b0; ram_data_ok = 1'b0;
            if (op_ok) done = 1'b1;
         end
      end
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_rdata"}, rdata_m, exp_rdata);
      check({tag, "_ram_reqs"}, 32'(nreq), 32'(exp_reqs));
      cpu_req = 1'b0;
      @(posedge clk); #1;
   endtask

   // Invalidate-all; counts cycles from the sampling edge to inv_done
   task automatic do_inv(input string tag);
      int cyc;
      inv_req = 1'b1; cyc = 0;
      @(posedge clk); #1;
      while (!inv_done_m && cyc < 100) begin
         @(posedge clk); #1; cyc++;
      end
      check({tag, "_cycles"}, 32'(cyc), 32'd16);
      inv_req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_ok", {31'd0, op_ok}, 32'd0);
      check("rst_rdata", rdata_m, 32'h0);
      check("rst_inv_done", {31'd0, inv_done_m}, 32'd0);
      check("rst_ram_req", {31'd0, ram_req_m}, 32'd0);
      check("rst_uncached", {31'd0, ram_uc_m}, 32'd0);
      check("rst_ram_addr", ram_addr_m, 32'h0);
      check("rst_ram_len", {24'd0, ram_len_m}, 32'd0);
      check("ram_wr", {31'd0, ram_wr_m}, 32'd0);
      check("ram_wdata", ram_wdata_m, 32'h0);
      cache_rst = 1'b0;
      @(posedge clk); #1;

      // Cold miss, then hits in the refilled line
      fetch("cold", 32'h8000_0040, 1, 1'b0, 32'h8000_0040, 16, 32'h1000, 32'h1000, lat);
      fetch("hit", 32'h8000_0044, 0, 1'b0, 32'h0, 16, 32'h0, 32'h1001, lat);
      check("hit_latency", 32'(lat), 32'd2);
      ram_beat_ok = 1'b1; ram_data_ok = 1'b1; ram_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      ram_beat_ok = 1'b0; ram_data_ok = 1'b0;
      check("stray_ok", {31'd0, op_ok}, 32'd0);
      check("stray_req", {31'd0, ram_req_m}, 32'd0);
      fetch("hit_w14", 32'h8000_0078, 0, 1'b0, 32'h0, 16, 32'h0, 32'h100E, lat);
      check("hit_w14_latency", 32'(lat), 32'd2);

      // Fill two more lines, invalidate, all three miss
      fetch("fill2", 32'h8000_0480, 1, 1'b0, 32'h8000_0480, 16, 32'h2000, 32'h2000, lat);
      fetch("fill3", 32'h8000_08C4, 1, 1'b0, 32'h8000_08C0, 16, 32'h3000, 32'h3001, lat);
      do_inv("inv1");
      fetch("post_inv1", 32'h8000_0040, 1, 1'b0, 32'h8000_0040, 16, 32'h1100, 32'h1100, lat);
      fetch("post_inv2", 32'h8000_0480, 1, 1'b0, 32'h8000_0480, 16, 32'h2100, 32'h2100, lat);
      fetch("post_inv3", 32'h8000_08C4, 1, 1'b0, 32'h8000_08C0, 16, 32'h3100, 32'h3101, lat);

      // Invalidate and fetch together: invalidate first, then the fetch misses
      cpu_addr = 32'h8000_0480; cpu_req = 1'b1;
      do_inv("inv2");
      fetch("inv_then_fetch", 32'h8000_0480, 1, 1'b0, 32'h8000_0480, 16, 32'h2200, 32'h2200, lat);

      // LRU at index 1: tags 0..4, tag 0 again, tag 5
      for (int t = 0; t < 5; t++)
         fetch("lru_fill", (32'(t) << 10) | 32'h40, 1, 1'b0, (32'(t) << 10) | 32'h40, 16,
               32'h4000 + 32'(t) * 32'h100, 32'h4000 + 32'(t) * 32'h100, lat);
      fetch("lru_t0_again", 32'h0000_0040, 1, 1'b0, 32'h0000_0040, 16, 32'h4000, 32'h4000, lat);
      fetch("lru_t5", 32'h0000_1440, 1, 1'b0, 32'h0000_1440, 16, 32'h4500, 32'h4500, lat);
      fetch("lru_t0_hit", 32'h0000_0040, 0, 1'b0, 32'h0, 16, 32'h0, 32'h4000, lat);
      check("lru_t0_latency", 32'(lat), 32'd2);
      fetch("lru_t4_hit", 32'h0000_1044, 0, 1'b0, 32'h0, 16, 32'h0, 32'h4401, lat);
      fetch("lru_t1_miss", 32'h0000_0440, 1, 1'b0, 32'h0000_0440, 16, 32'h4100, 32'h4100, lat);

      // kseg1 uncached: never allocates
      fetch("uc1", 32'hBFC0_0000, 1, 1'b1, 32'hBFC0_0000, 1, 32'h2410_0001, 32'h2410_0001, lat);
      fetch("uc2", 32'hBFC0_0000, 1, 1'b1, 32'hBFC0_0000, 1, 32'h2410_0002, 32'h2410_0002, lat);

      // Reset after beat 7 of a refill
      cpu_addr = 32'h8000_1040; cpu_req = 1'b1; n = 0;
      while (!ram_req_m && n < 20) begin
         @(posedge clk); #1; n++;
      end
      check("mid_rst_req_seen", {31'd0, ram_req_m}, 32'd1);
      check("mid_rst_ram_addr", ram_addr_m, 32'h8000_1040);
      ram_addr_ok = 1'b1;
      @(posedge clk); #1;
      ram_addr_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ram_rdata = 32'h6000 + 32'(i); ram_beat_ok = 1'b1;
         @(posedge clk); #1;
      end
      ram_beat_ok = 1'b0;
      cache_rst = 1'b1; cpu_req = 1'b0;
      #1;
      check("mid_rst_ram_req", {31'd0, ram_req_m}, 32'd0);
      check("mid_rst_ok", {31'd0, op_ok}, 32'd0);
      check("mid_rst_rdata", rdata_m, 32'h0);
      @(posedge clk); #1;
      cache_rst = 1'b0;
      for (int i = 8; i < 16; i++) begin
         ram_rdata = 32'h6000 + 32'(i); ram_beat_ok = 1'b1; ram_data_ok = (i == 15);
         @(posedge clk); #1;
         check("trail_ok", {31'd0, op_ok}, 32'd0);
         check("trail_req", {31'd0, ram_req_m}, 32'd0);
      end
      ram_beat_ok = 1'b0; ram_data_ok = 1'b0;
      fetch("post_rst", 32'h8000_1040, 1, 1'b0, 32'h8000_1040, 16, 32'h7000, 32'h7000, lat);

      // 2-way, 64 sets, 8-word lines: three tags conflicting at index 1
      sel2 = 1'b1;
      @(posedge clk); #1;
      fetch("w2_A", 32'h0000_002C, 1, 1'b0, 32'h0000_0020, 8, 32'h5000, 32'h5003, lat);
      fetch("w2_B", 32'h0000_0820, 1, 1'b0, 32'h0000_0820, 8, 32'h5100, 32'h5100, lat);
      fetch("w2_A_hit1", 32'h0000_0024, 0, 1'b0, 32'h0, 8, 32'h0, 32'h5001, lat);
      check("w2_hit_latency", 32'(lat), 32'd2);
      fetch("w2_C", 32'h0000_1020, 1, 1'b0, 32'h0000_1020, 8, 32'h5200, 32'h5200, lat);
      fetch("w2_A_hit2", 32'h0000_0020, 0, 1'b0, 32'h0, 8, 32'h0, 32'h5000, lat);
      fetch("w2_B_again", 32'h0000_0820, 1, 1'b0, 32'h0000_0820, 8, 32'h5300, 32'h5300, lat);
      fetch("w2_A_hit3", 32'h0000_003C, 0, 1'b0, 32'h0, 8, 32'h0, 32'h5007, lat);
      fetch("w2_C_again", 32'h0000_1020, 1, 1'b0, 32'h0000_1020, 8, 32'h5400, 32'h5400, lat);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
